// File: rtl/sram_async_ctrl.sv
// rtl/sram_async_ctrl.sv - asynchronous SRAM controller with registered strobes and tri-state data bus
module sram_async_ctrl #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 18,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [AWIDTH-1:0]     req_addr,
    input  logic [DWIDTH-1:0]     req_wdata,
    input  logic [DWIDTH/8-1:0]   req_wbe,
    output logic [DWIDTH-1:0]     rdata,
    output logic                  rdata_valid,
    inout  wire  [DWIDTH-1:0]     sram_dio,
    output logic [AWIDTH-1:0]     sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DWIDTH/8-1:0]   sram_be_n
);

    localparam int BW   = DWIDTH / 8;
    localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [BW-1:0]     wbe_q, wbe_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dio_oe_q, dio_oe_d;
    logic [BW-1:0]     be_n_q, be_n_d;
    logic              wr_phase;

    assign req_ready = (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wbe_d    = wbe_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wbe_d   = req_wbe;
                    if (req_we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = CW'(RD_WAIT - 1);
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rdata_d  = sram_dio;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CW'(WR_WAIT - 1);
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight off flops
        wr_phase = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        ce_n_d   = (state_d == IDLE);
        oe_n_d   = (state_d != RD);
        we_n_d   = (state_d != WR_PULSE);
        dio_oe_d = wr_phase;
        be_n_d   = (state_d == RD) ? '0 : (wr_phase ? ~wbe_d : '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            dio_oe_q <= 1'b0;
            be_n_q   <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            dio_oe_q <= dio_oe_d;
            be_n_q   <= be_n_d;
        end
    end

    // Write payload needs no reset: it is only ever driven out behind dio_oe_q
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        wbe_q   <= wbe_d;
    end

    assign sram_dio    = dio_oe_q ? wdata_q : {DWIDTH{1'bz}};
    assign sram_addr   = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// tb/tb_sram_async_ctrl.sv - directed self-checking bench for sram_async_ctrl (x16 and x32 instances)
module tb_sram_async_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_we, sel;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wbe;

    logic        rdy_a, rv_a, ce_a, oe_a, we_a;
    logic [15:0] rdata_a;
    logic [17:0] addr_a;
    logic [1:0]  be_a;
    wire  [15:0] dio_a;

    logic        rdy_b, rv_b, ce_b, oe_b, we_b;
    logic [31:0] rdata_b;
    logic [17:0] addr_b;
    logic [3:0]  be_b;
    wire  [31:0] dio_b;

    sram_async_ctrl #(.DWIDTH(16), .AWIDTH(18), .RD_WAIT(2), .WR_WAIT(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata[15:0]), .req_wbe(req_wbe[1:0]),
        .rdata(rdata_a), .rdata_valid(rv_a), .sram_dio(dio_a), .sram_addr(addr_a),
        .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(we_a), .sram_be_n(be_a)
    );

    sram_async_ctrl #(.DWIDTH(32), .AWIDTH(18), .RD_WAIT(1), .WR_WAIT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wbe(req_wbe),
        .rdata(rdata_b), .rdata_valid(rv_b), .sram_dio(dio_b), .sram_addr(addr_b),
        .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(we_b), .sram_be_n(be_b)
    );

    // SRAM models with backdoor preload; probe pulls the bus to 0 to expose a stray driver
    logic [15:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic        ld_a = 1'b0, ld_b = 1'b0, probe_a = 1'b0;
    logic [7:0]  ld_idx;
    logic [31:0] ld_val;

    assign dio_a = (!ce_a && !oe_a && we_a) ? mem_a[addr_a[7:0]] : 16'bz;
    assign dio_a = probe_a ? 16'h0000 : 16'bz;
    assign dio_b = (!ce_b && !oe_b && we_b) ? mem_b[addr_b[7:0]] : 32'bz;

    always @(posedge we_a or posedge ld_a) begin
        if (ld_a) mem_a[ld_idx] <= ld_val[15:0];
        else for (int i = 0; i < 2; i++) if (!be_a[i]) mem_a[addr_a[7:0]][8*i +: 8] <= dio_a[8*i +: 8];
    end

    always @(posedge we_b or posedge ld_b) begin
        if (ld_b) mem_b[ld_idx] <= ld_val;
        else for (int i = 0; i < 4; i++) if (!be_b[i]) mem_b[addr_b[7:0]][8*i +: 8] <= dio_b[8*i +: 8];
    end

    wire        o_rdy   = sel ? rdy_b : rdy_a;
    wire        o_oe    = sel ? oe_b : oe_a;
    wire        o_we    = sel ? we_b : we_a;
    wire        o_rv    = sel ? rv_b : rv_a;
    wire [3:0]  o_be    = sel ? be_b : {2'b11, be_a};
    wire [31:0] o_rdata = sel ? rdata_b : {16'h0000, rdata_a};
    wire [31:0] o_dio   = sel ? dio_b : {16'h0000, dio_a};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic to_b, input logic [7:0] idx, input logic [31:0] val);
        ld_idx = idx;
        ld_val = val;
        if (to_b) ld_b = 1'b1; else ld_a = 1'b1;
        #1;
        ld_a = 1'b0;
        ld_b = 1'b0;
        #1;
    endtask

    // Issue one request from posedge+1, scramble req_* while busy, and measure the strobes
    task automatic run(input logic we, input logic [17:0] addr, input logic [31:0] wd, input logic [3:0] wbe,
                       output int busy, output int oe_lo, output int we_lo, output int vld_at,
                       output logic [3:0] be_seen, output logic [31:0] rd, output logic [31:0] dio_seen);
        busy = 0; oe_lo = 0; we_lo = 0; vld_at = -1; be_seen = 4'hF; rd = 0; dio_seen = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wbe = wbe;
        @(negedge clk);
        chk("ready_before_req", 32'(o_rdy), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            req_we = 1'($urandom); req_addr = 18'($urandom); req_wdata = $urandom; req_wbe = 4'($urandom);
            @(negedge clk);
            if (!o_rdy) busy++;
            if (!o_oe) oe_lo++;
            if (!o_we) begin we_lo++; be_seen = o_be; dio_seen = o_dio; end
            if (o_rv && vld_at < 0) begin vld_at = n; rd = o_rdata; end
            @(posedge clk); #1;
        end
        if (vld_at < 0) rd = o_rdata;
    endtask

    int          busy, oe_lo, we_lo, vld_at, cnt;
    logic [3:0]  be_seen;
    logic [31:0] rd, dio_seen;
    logic        found;

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_wbe = '0;
        preload(1'b0, 8'h12, 32'h0000BEEF);
        preload(1'b0, 8'h34, 32'h00001234);
        preload(1'b1, 8'h09, 32'hAABBCCDD);

        @(negedge clk);
        chk("rst_ce_n", 32'(ce_a), 1);
        chk("rst_oe_n", 32'(oe_a), 1);
        chk("rst_we_n", 32'(we_a), 1);
        chk("rst_be_n_a", 32'(be_a), 32'h3);
        chk("rst_be_n_b", 32'(be_b), 32'hF);
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_rdata", 32'(rdata_a), 0);
        chk("rst_rvalid", 32'(rv_a), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(rdy_a), 1);
        @(posedge clk); #1;

        run(1'b0, 18'h00012, 32'h0, 4'h0, busy, oe_lo, we_lo, vld_at, be_seen, rd, dio_seen);
        chk("rd_oe_cycles", oe_lo, 2);
        chk("rd_busy", busy, 2);
        chk("rd_latency", vld_at, 2);
        chk("rd_data", rd, 32'hBEEF);
        chk("rd_no_we", we_lo, 0);

        run(1'b1, 18'h00034, 32'hA55A, 4'b0010, busy, oe_lo, we_lo, vld_at, be_seen, rd, dio_seen);
        chk("wr_we_cycles", we_lo, 2);
        chk("wr_busy", busy, 4);
        chk("wr_be_n", 32'(be_seen), 32'hD);
        chk("wr_dio", dio_seen, 32'hA55A);
        chk("wr_no_oe", oe_lo, 0);
        chk("wr_no_rvalid", vld_at, -1);
        chk("wr_rdata_hold", rd, 32'hBEEF);
        chk("wr_mem", 32'(mem_a[8'h34]), 32'hA534);

        run(1'b1, 18'h00034, 32'hFFFF, 4'b0000, busy, oe_lo, we_lo, vld_at, be_seen, rd, dio_seen);
        chk("wr0_we_cycles", we_lo, 2);
        chk("wr0_be_n", 32'(be_seen), 32'hF);
        chk("wr0_busy", busy, 4);
        chk("wr0_mem", 32'(mem_a[8'h34]), 32'hA534);

        run(1'b0, 18'h00034, 32'h0, 4'h0, busy, oe_lo, we_lo, vld_at, be_seen, rd, dio_seen);
        chk("rd2_latency", vld_at, 2);
        chk("rd2_data", rd, 32'hA534);

        // Write then read the same address with req_valid held high throughout
        req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00056; req_wdata = 32'h5A5A; req_wbe = 4'h3;
        @(posedge clk); #1;
        req_we = 1'b0;
        vld_at = -1; rd = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 4) begin
                chk("b2b_ready_idle", 32'(rdy_a), 1);
                chk("b2b_oe_high", 32'(oe_a), 1);
                probe_a = 1'b1; #1;
                chk("b2b_dio_hiz", 32'(dio_a), 0);
                probe_a = 1'b0;
            end
            if (n == 5) chk("b2b_oe_low", 32'(oe_a), 0);
            if (rv_a && vld_at < 0) begin vld_at = n; rd = 32'(rdata_a); end
            @(posedge clk); #1;
            if (n == 4) req_valid = 1'b0;
        end
        chk("b2b_latency", vld_at, 7);
        chk("b2b_data", rd, 32'h5A5A);

        // Reset during the write pulse
        req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00078; req_wdata = 32'hF0F0; req_wbe = 4'h3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            @(negedge clk);
            if (!we_a) found = 1'b1;
        end
        chk("abort_pulse_seen", 32'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we_n", 32'(we_a), 1);
        chk("abort_ce_n", 32'(ce_a), 1);
        chk("abort_addr", 32'(addr_a), 0);
        probe_a = 1'b1; #1;
        chk("abort_dio_hiz", 32'(dio_a), 0);
        probe_a = 1'b0;
        rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n == 0) chk("abort_ready", 32'(rdy_a), 1);
            if (!we_a) cnt++;
        end
        chk("abort_no_replay", cnt, 0);
        @(posedge clk); #1;

        sel = 1'b1;
        run(1'b1, 18'h00009, 32'h11223344, 4'b1010, busy, oe_lo, we_lo, vld_at, be_seen, rd, dio_seen);
        chk("b_wr_we_cycles", we_lo, 3);
        chk("b_wr_busy", busy, 5);
        chk("b_wr_be_n", 32'(be_seen), 32'h5);
        chk("b_wr_dio", dio_seen, 32'h11223344);
        chk("b_wr_mem", mem_b[8'h09], 32'h11BB33DD);

        run(1'b0, 18'h00009, 32'h0, 4'h0, busy, oe_lo, we_lo, vld_at, be_seen, rd, dio_seen);
        chk("b_rd_oe_cycles", oe_lo, 1);
        chk("b_rd_busy", busy, 1);
        chk("b_rd_latency", vld_at, 1);
        chk("b_rd_data", rd, 32'h11BB33DD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_async_ctrl.md
SRAM_ASYNC_CTRL -- requirements
Module: sram_async_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: SRAM data width; must be a multiple of 8.
REQ-002 SHALL have parameter AWIDTH, default 18: SRAM word-address width.
REQ-003 SHALL have parameter RD_WAIT, default 2: read access cycles; must be >= 1.
REQ-004 SHALL have parameter WR_WAIT, default 2: write-enable pulse cycles; must be >= 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid, input, 1 bit: request present.
REQ-008 SHALL have port req_ready, output, 1 bit: controller accepts a request this cycle.
REQ-009 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, AWIDTH bits: word address.
REQ-011 SHALL have port req_wdata, input, DWIDTH bits: write data.
REQ-012 SHALL have port req_wbe, input, DWIDTH/8 bits: write byte-lane enables.
REQ-013 SHALL have port rdata, output, DWIDTH bits: registered read data.
REQ-014 SHALL have port rdata_valid, output, 1 bit: one-cycle pulse when rdata is updated.
REQ-015 SHALL have port sram_dio, inout, DWIDTH bits: SRAM data bus.
REQ-016 SHALL have port sram_addr, output, AWIDTH bits: SRAM address.
REQ-017 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n, outputs, 1 bit each: SRAM chip, output and write strobes, active-low.
REQ-018 SHALL have port sram_be_n, output, DWIDTH/8 bits: per-byte lane selects, active-low; bit 0 = LB, bit 1 = UB for a x16 part.

Function
REQ-019 SHALL drive all sram_* outputs and the sram_dio output enable from flops only; no combinational path from clk or req_* to any strobe.
REQ-020 SHALL implement FSM states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-022 SHALL latch req_addr, req_wdata, req_wbe and req_we on acceptance; later req_* changes SHALL NOT affect the transaction in flight.
REQ-023 On acceptance, SHALL transition IDLE->RD if req_we=0, else IDLE->WR_SETUP.
REQ-024 In IDLE, SHALL drive sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n all 1 and sram_dio Hi-Z; sram_addr holds its last value.
REQ-025 In RD, SHALL drive sram_ce_n=0, sram_oe_n=0, sram_we_n=1, sram_be_n all 0 and sram_dio Hi-Z, for exactly RD_WAIT cycles.
REQ-026 On the edge ending the last RD cycle, SHALL capture sram_dio into rdata, return to IDLE, and hold rdata_valid=1 for exactly the following cycle.
REQ-027 Read latency SHALL be RD_WAIT edges from the acceptance edge to rdata_valid=1; req_ready SHALL be 1 in the same cycle, so back-to-back reads are allowed.
REQ-028 WR_SETUP SHALL last 1 cycle: sram_ce_n=0, sram_oe_n=1, sram_we_n=1, sram_dio driven with latched wdata, sram_be_n = ~latched wbe.
REQ-029 WR_PULSE SHALL last WR_WAIT cycles with sram_we_n=0; all other signals as in WR_SETUP.
REQ-030 WR_HOLD SHALL last 1 cycle with sram_we_n=1 and data, address and sram_be_n still driven, then go to IDLE.
REQ-031 A write SHALL occupy WR_WAIT+2 cycles; req_ready SHALL return to 1 WR_WAIT+2 edges after acceptance.
REQ-032 A write with req_wbe all 0 SHALL run the same timing with sram_be_n all 1, so no byte is modified.
REQ-033 SHALL never drive sram_dio while sram_oe_n=0, including on read-to-write and write-to-read turnaround.
REQ-034 rdata SHALL hold its value except on a read capture; rdata_valid SHALL never assert for writes.
REQ-035 Cycle counter width SHALL be clog2(max(RD_WAIT,WR_WAIT)+1); the counter reloads on entry to RD and WR_PULSE.
REQ-036 SHALL drive sram_dio with a generic tri-state assignment (no vendor primitive).

Reset
REQ-037 rst_n=0 SHALL immediately, without waiting for a clock edge, force: FSM to IDLE, sram_we_n=1, sram_ce_n=1, sram_oe_n=1, sram_be_n all 1, sram_dio Hi-Z, sram_addr=0, rdata=0, rdata_valid=0, counter=0.
REQ-038 Reset asserted mid-write SHALL abort the write pulse immediately; the transaction is dropped and SHALL NOT be replayed after reset.
REQ-039 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-040 Read, RD_WAIT=2, addr 0x00012, SRAM model returns 0xBEEF -> sram_oe_n low for 2 cycles; rdata=0xBEEF with rdata_valid high for 1 cycle, 2 edges after acceptance.
REQ-041 Write addr 0x00034, data 0xA55A, wbe=2'b10, WR_WAIT=2 -> sram_we_n low exactly 2 cycles; sram_be_n=2'b01; model upper byte=0xA5, lower byte unchanged; req_ready low for 4 cycles.
REQ-042 Back-to-back write then read to the same address with req_valid held high -> sram_dio Hi-Z before sram_oe_n falls; read returns the written data.
REQ-043 rst_n pulled low during WR_PULSE -> sram_we_n=1 and sram_dio Hi-Z before the next clock edge; req_ready=1 after release.
REQ-044 req_* inputs changed every cycle while busy -> transaction uses the values latched at acceptance only.
REQ-045 Rerun with DWIDTH=32, RD_WAIT=1, WR_WAIT=3 -> 4-bit sram_be_n matches ~wbe; timing per REQ-027 and REQ-031.
